// File: rtl/vec_add_seq.sv
// rtl/vec_add_seq.sv - packed SIMD add/sub sequencer, one byte per cycle through an 8-bit Kogge-Stone adder
// The ks_adder helper sits in this file so the block stays self-contained.

module ks_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g0, p0, g1, g2, g3;
  logic [7:2] p1;
  logic [7:4] p2;

  always_comb begin
    p0 = a ^ b;
    g0 = a & b;
    // Fold cin into bit 0 so every prefix G[i] is directly the carry into bit i+1
    g0[0] = (a[0] & b[0]) | (p0[0] & cin);

    g1 = g0;
    for (int i = 1; i < 8; i++) g1[i] = g0[i] | (p0[i] & g0[i-1]);
    for (int i = 2; i < 8; i++) p1[i] = p0[i] & p0[i-1];

    g2 = g1;
    for (int i = 2; i < 8; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    for (int i = 4; i < 8; i++) p2[i] = p1[i] & p1[i-2];

    g3 = g2;
    for (int i = 4; i < 8; i++) g3[i] = g2[i] | (p2[i] & g2[i-4]);

    sum  = p0 ^ {g3[6:0], cin};
    cout = g3[7];
  end
endmodule

module vec_add_seq #(
  parameter int VLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [1:0]        ew,
  input  logic [VLEN-1:0]   a,
  input  logic [VLEN-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   result,
  output logic [VLEN/8-1:0] cout,
  output logic              busy
);
  localparam int NB = VLEN / 8;
  localparam int IW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [VLEN-1:0] a_reg, b_reg;
  logic            sub_reg;
  logic [1:0]      ew_reg;
  logic            carry_reg;

  logic [1:0]      lane_mask;
  logic            elem_lo, elem_hi, last_byte;
  logic [IW+2:0]   bit_base;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte position within the element: ew 00 -> 1 byte, 01 -> 2 bytes, 10/11 -> 4 bytes
  assign lane_mask = (ew_reg == 2'b00) ? 2'b00 : (ew_reg == 2'b01) ? 2'b01 : 2'b11;
  assign elem_lo   = (idx[1:0] & lane_mask) == 2'b00;
  assign elem_hi   = (idx[1:0] & lane_mask) == lane_mask;
  assign last_byte = idx == IW'(NB - 1);
  assign bit_base  = {idx, 3'b000};

  assign add_a   = a_reg[bit_base +: 8];
  assign add_b   = sub_reg ? ~b_reg[bit_base +: 8] : b_reg[bit_base +: 8];
  assign add_cin = elem_lo ? sub_reg : carry_reg;

  ks_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      ew_reg    <= 2'b00;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_reg   <= a;
        b_reg   <= b;
        sub_reg <= op_sub;
        ew_reg  <= ew;
        idx     <= '0;
      end else if (state == RUN) begin
        result[bit_base +: 8] <= add_sum;
        carry_reg             <= add_cout;
        cout[idx]             <= elem_hi ? add_cout : 1'b0;
        idx                   <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vec_add_seq.sv
// tb/tb_vec_add_seq.sv - randomized self-checking bench for vec_add_seq against a per-element arithmetic model

module tb_vec_add_seq;
  localparam int VLEN = 32;
  localparam int NB   = VLEN / 8;

  logic            clk, rst_n;
  logic            in_valid, in_ready, op_sub, out_valid, out_ready, busy;
  logic [1:0]      ew;
  logic [VLEN-1:0] a, b, result;
  logic [NB-1:0]   cout;

  int n_checks = 0;
  int n_errors = 0;

  vec_add_seq #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .ew(ew), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each element is an independent w-bit add of a + b (or a + ~b + 1); carry out lands on its top byte
  function automatic void model(input logic [VLEN-1:0] ma, input logic [VLEN-1:0] mb,
                                input logic ms, input logic [1:0] mew,
                                output logic [VLEN-1:0] r, output logic [NB-1:0] c);
    int w;
    longint mask, ae, be, s;
    w    = (mew == 2'b00) ? 8 : (mew == 2'b01) ? 16 : 32;
    mask = (longint'(1) << w) - 1;
    r = '0;
    c = '0;
    for (int e = 0; e < VLEN / w; e++) begin
      ae = (longint'(ma) >> (e * w)) & mask;
      be = (longint'(mb) >> (e * w)) & mask;
      s  = ae + (ms ? (~be & mask) : be) + longint'(ms);
      r  = r | (VLEN'(s & mask) << (e * w));
      c[(e + 1) * (w / 8) - 1] = 1'((s >> w) & 1);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [VLEN-1:0] ta, input logic [VLEN-1:0] tb,
                        input logic ts, input logic [1:0] te, input int hold);
    logic [VLEN-1:0] er;
    logic [NB-1:0]   ec;
    int cyc;
    model(ta, tb, ts, te, er, ec);
    a = ta; b = tb; op_sub = ts; ew = te; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op_sub = ~ts; ew = 2'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(NB));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " done flags"}, {61'd0, busy, in_ready, out_valid}, 64'b101);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 3);
      tick();
      in_valid = 1'b0;
      check({tag, " held"}, {out_valid, in_ready, 22'd0, cout, result}, {1'b1, 1'b0, 22'd0, ec, er});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, {61'd0, busy, in_ready, out_valid}, 64'b010);
    check({tag, " idle keeps result"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [VLEN-1:0] qr[$];
    logic [NB-1:0]   qc[$];
    logic [VLEN-1:0] er;
    logic [NB-1:0]   ec;
    int accept_cyc[$];
    int seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; ew = 2'b00;
    a = '0; b = '0;
    #1;
    check("reset flags", {61'd0, busy, in_ready, out_valid}, 64'b010);
    check("reset result", 64'(result), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    run_op("t1 ew8 add", 32'h01FF7F80, 32'h01010180, 1'b0, 2'b00, 0);
    run_op("t2 ew32 add", 32'h0000FFFF, 32'h00000001, 1'b0, 2'b10, 0);
    run_op("t2 ew32 wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b10, 0);
    run_op("t3 ew16 sub", 32'h00050000, 32'h00010001, 1'b1, 2'b01, 0);
    run_op("t4 backpressure", 32'h12345678, 32'h9ABCDEF0, 1'b0, 2'b01, 10);

    // Abort mid-RUN: reset takes effect without waiting for a clock
    a = 32'hDEADBEEF; b = 32'h01234567; op_sub = 1'b0; ew = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5 abort flags", {61'd0, busy, in_ready, out_valid}, 64'b010);
    check("t5 abort result", 64'(result), 64'd0);
    check("t5 abort cout", 64'(cout), 64'd0);
    tick();
    rst_n = 1'b1;
    run_op("t5 fresh add", 32'h10101010, 32'h01010101, 1'b0, 2'b00, 0);

    run_op("t6 ew11 add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 2'b11, 0);

    for (int k = 0; k < 20; k++)
      run_op("rand", $urandom, $urandom, 1'($urandom), 2'($urandom), $urandom_range(0, 4));

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (qr.size() > 0) begin
          check("b2b result", 64'(result), 64'(qr.pop_front()));
          check("b2b cout", 64'(cout), 64'(qc.pop_front()));
          seen++;
        end
      end
      if (in_ready) begin
        a = $urandom; b = $urandom; op_sub = 1'($urandom); ew = 2'($urandom);
        model(a, b, op_sub, ew, er, ec);
        qr.push_back(er);
        qc.push_back(ec);
        accept_cyc.push_back(cyc);
      end
      tick();
    end
    in_valid = 1'b0;
    check("b2b completions", 64'(seen >= 5), 64'd1);
    for (int i = 1; i < accept_cyc.size(); i++)
      check("b2b spacing", 64'(accept_cyc[i] - accept_cyc[i-1]), 64'(NB + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vec_add_seq.md
Name: vec_add_seq

Overview:
Sequencing controller that performs packed SIMD add/subtract on a VLEN-bit vector by time-multiplexing one 8-bit ks_adder, which is instantiated inside this block. It processes one byte per cycle, LSB byte first. It chains the carry between bytes inside an element and re-seeds it at each element boundary. It sits between the vector ALU issue stage and the writeback stage, with valid/ready handshakes on both sides.

Parameters:
VLEN, 32, vector width in bits; must be a multiple of 32. NB = VLEN/8 byte steps.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept; high only in IDLE
op_sub  input  1  0 = a+b, 1 = a-b
ew  input  2  element width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = treated as 32b
a  input  VLEN  operand A
b  input  VLEN  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  VLEN  packed element results
cout  output  NB  bit k = carry out of byte k if byte k is the top byte of an element, else 0
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n. While rst_n = 0:
  - state = IDLE; result = 0; cout = 0; out_valid = 0; busy = 0; in_ready = 1.
  - Byte index, carry register and operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b, op_sub and ew; set idx = 0; go to RUN.
  - result and cout keep their previous values until overwritten.
- RUN, one byte per cycle:
  - Adder a-input = a_reg[8*idx +: 8].
  - Adder b-input = b_reg byte, inverted when op_sub = 1.
  - Adder cin:
    - At an element's low byte, cin = op_sub. Element low byte means idx mod (ew_bytes) == 0, with ew_bytes = 1, 2 or 4.
    - Otherwise cin = the carry register.
  - At the clock edge:
    - result byte idx <= adder sum.
    - Carry register <= adder carry.
    - cout[idx] <= adder carry if idx is an element's top byte, else 0.
    - idx increments.
  - After idx = NB-1 the block goes to DONE.
- DONE:
  - out_valid = 1.
  - result and cout are held stable while out_ready = 0.
  - On out_ready: go to IDLE and set out_valid = 0 on the next cycle.
  - No same-cycle re-accept.
- Latency and throughput:
  - Acceptance edge at T0 → out_valid rises after edge T0+NB (4 cycles for VLEN = 32).
  - Maximum throughput is one operation per NB+2 cycles.
- Input rules:
  - in_valid with in_ready = 0 is ignored; it is not queued.
  - Inputs are sampled only at the acceptance edge; later changes have no effect.
- Subtract semantics: a + ~b + 1 per element. cout = 1 means no borrow.
- Carry never crosses an element boundary, and no carry crosses the vector top.
- Reset asserted mid-RUN or mid-DONE aborts the operation and all state returns to reset values.
- Re-accept after reset is allowed on the first clock edge with rst_n = 1.

Test Plan:
1. ew=00, add, a=0x01FF7F80, b=0x01010180 → result=0x02008000, cout=4'b0101, out_valid exactly 4 cycles after accept.
2. ew=10, add, a=0x0000FFFF, b=0x00000001 → result=0x00010000, cout=0000. Then a=0xFFFFFFFF, b=1 → result=0x00000000, cout=4'b1000.
3. ew=01, sub, a=0x00050000, b=0x00010001 → result=0x0004FFFF, cout=4'b1000 (low half borrows, high half does not).
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → result, cout and out_valid stay stable; in_ready=0; a pulsed in_valid is dropped. Release → IDLE next cycle, in_ready=1.
5. Assert rst_n=0 during RUN at idx=2 → immediately out_valid=0, result=0, cout=0, busy=0, in_ready=1. A fresh ew=00 add of 0x10101010+0x01010101 → 0x11111111, cout=0000.
6. ew=11, add, a=0x7FFFFFFF, b=1 → behaves as 32b: result=0x80000000, cout=0000. Back-to-back ops with in_valid held high are accepted every 6 cycles.
